// File: rtl/fract_cmp_sub_pipe.sv
// Two-stage mantissa add/subtract unit for the FP add/sub datapath.
// S1 compares the aligned mantissas; S2 forms the magnitude result and its leading-zero count.
module fract_cmp_sub_pipe #(
    parameter  int FRACT_W = 24,
    parameter  int TAG_W   = 4,
    localparam int LZC_W   = $clog2(FRACT_W + 2)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [FRACT_W-1:0] i_fract_a,
    input  logic [FRACT_W-1:0] i_fract_b,
    input  logic               i_op,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [FRACT_W:0]   o_result,
    output logic               o_swap,
    output logic               o_equal,
    output logic [LZC_W-1:0]   o_lzc,
    output logic [TAG_W-1:0]   o_tag
);

    // ------------------------------------------------------------------
    // Handshake: combinational ready chain, no skid buffer
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_load;
    logic s2_load;
    logic accept;

    assign s2_load = !s2_valid_reg || i_ready;
    assign s1_load = !s1_valid_reg || s2_load;
    assign o_ready = s1_load;
    assign accept  = i_valid && s1_load;

    // ------------------------------------------------------------------
    // S1: compare
    // ------------------------------------------------------------------
    logic [FRACT_W-1:0] s1_a_reg;
    logic [FRACT_W-1:0] s1_b_reg;
    logic               s1_op_reg;
    logic               s1_gt_b_reg;
    logic               s1_eq_reg;
    logic [TAG_W-1:0]   s1_tag_reg;

    logic [FRACT_W:0]   cmp_diff;
    logic               gt_b_next;
    logic               eq_next;

    // The borrow of the widened A-B tells us B > A; an all-zero difference means A == B.
    assign cmp_diff  = {1'b0, i_fract_a} - {1'b0, i_fract_b};
    assign gt_b_next = cmp_diff[FRACT_W];
    assign eq_next   = (cmp_diff == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= 1'b0;
            s1_gt_b_reg  <= 1'b0;
            s1_eq_reg    <= 1'b0;
            s1_tag_reg   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= i_valid;
            end
            if (accept) begin
                s1_a_reg    <= i_fract_a;
                s1_b_reg    <= i_fract_b;
                s1_op_reg   <= i_op;
                s1_gt_b_reg <= gt_b_next;
                s1_eq_reg   <= eq_next;
                s1_tag_reg  <= i_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: compute magnitude result
    // ------------------------------------------------------------------
    logic [FRACT_W:0] ext_a;
    logic [FRACT_W:0] ext_b;
    logic [FRACT_W:0] sum_ab;
    logic [FRACT_W:0] diff_ab;
    logic [FRACT_W:0] diff_ba;
    logic [FRACT_W:0] result_next;

    assign ext_a   = {1'b0, s1_a_reg};
    assign ext_b   = {1'b0, s1_b_reg};
    assign sum_ab  = ext_a + ext_b;
    assign diff_ab = ext_a - ext_b;
    assign diff_ba = ext_b - ext_a;

    always_comb begin
        result_next = sum_ab;
        if (s1_op_reg) begin
            result_next = s1_gt_b_reg ? diff_ba : diff_ab;
        end
    end

    // Leading-one detect: a bit is the leading one when it is set and nothing above it is.
    logic [FRACT_W:0] above;
    logic [FRACT_W:0] lead;
    logic [LZC_W-1:0] lzc_next;

    assign above[FRACT_W] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < FRACT_W; gi++) begin : g_above
            assign above[gi] = above[gi+1] | result_next[gi+1];
        end
        for (gi = 0; gi <= FRACT_W; gi++) begin : g_lead
            assign lead[gi] = result_next[gi] & ~above[gi];
        end
    endgenerate

    // lead is one-hot (or zero), so OR-ing the per-bit counts selects the right one.
    always_comb begin
        lzc_next = '0;
        for (int i = 0; i <= FRACT_W; i++) begin
            if (lead[i]) begin
                lzc_next = lzc_next | LZC_W'(FRACT_W - i);
            end
        end
        if (result_next == '0) begin
            lzc_next = LZC_W'(FRACT_W + 1);
        end
    end

    logic [FRACT_W:0] s2_result_reg;
    logic             s2_swap_reg;
    logic             s2_equal_reg;
    logic [LZC_W-1:0] s2_lzc_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= '0;
            s2_swap_reg   <= 1'b0;
            s2_equal_reg  <= 1'b0;
            s2_lzc_reg    <= '0;
            s2_tag_reg    <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg <= result_next;
                s2_swap_reg   <= s1_op_reg & s1_gt_b_reg;
                s2_equal_reg  <= s1_eq_reg;
                s2_lzc_reg    <= lzc_next;
                s2_tag_reg    <= s1_tag_reg;
            end
        end
    end

    assign o_valid  = s2_valid_reg;
    assign o_result = s2_result_reg;
    assign o_swap   = s2_swap_reg;
    assign o_equal  = s2_equal_reg;
    assign o_lzc    = s2_lzc_reg;
    assign o_tag    = s2_tag_reg;

endmodule

// File: tb/tb_fract_cmp_sub_pipe.sv
// Bench for fract_cmp_sub_pipe: directed vectors, stall/reset scenarios and a random
// stream, all checked against an arithmetic reference model and an occupancy scoreboard.
module tb_fract_cmp_sub_pipe;

    localparam int FRACT_W = 24;
    localparam int TAG_W   = 4;
    localparam int LZC_W   = $clog2(FRACT_W + 2);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_valid;
    logic               o_ready;
    logic [FRACT_W-1:0] fract_a;
    logic [FRACT_W-1:0] fract_b;
    logic               op;
    logic [TAG_W-1:0]   tag;
    logic               o_valid;
    logic               i_ready;
    logic [FRACT_W:0]   o_result;
    logic               o_swap;
    logic               o_equal;
    logic [LZC_W-1:0]   o_lzc;
    logic [TAG_W-1:0]   o_tag;

    fract_cmp_sub_pipe #(.FRACT_W(FRACT_W), .TAG_W(TAG_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_fract_a (fract_a),
        .i_fract_b (fract_b),
        .i_op      (op),
        .i_tag     (tag),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_swap    (o_swap),
        .o_equal   (o_equal),
        .o_lzc     (o_lzc),
        .o_tag     (o_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRACT_W:0] res;
        logic             swap;
        logic             eq;
        logic [LZC_W-1:0] lzc;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   accepted;
    bit   saw_not_ready;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // Reference: magnitude add or subtract, then count zeros from the top bit down.
    function automatic exp_t model(input logic [FRACT_W-1:0] a, input logic [FRACT_W-1:0] b,
                                   input logic o, input logic [TAG_W-1:0] t, input int acc);
        exp_t e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r;
        int n = 0;
        if (!o)          r = ua + ub;
        else if (ua >= ub) r = ua - ub;
        else             r = ub - ua;
        e.res  = r[FRACT_W:0];
        e.swap = o && (ub > ua);
        e.eq   = (ua == ub);
        for (int i = FRACT_W; i >= 0; i--) begin
            if (e.res[i]) break;
            n++;
        end
        e.lzc = LZC_W'(n);
        e.tag = t;
        e.acc = acc;
        return e;
    endfunction

    // One clock: check outputs at the negedge, log any handshake, advance to posedge+1.
    task automatic cycle();
        int cnt;
        bit ev;
        @(negedge clk);
        accepted = 1'b0;
        if (rst_n) begin
            cnt = q.size();
            ev  = (cnt > 0) && (cyc - q[0].acc >= 2);
            check("o_ready", 64'(o_ready), 64'(!(cnt == 2 && !i_ready)));
            check("o_valid", 64'(o_valid), 64'(ev));
            if (!o_ready) saw_not_ready = 1'b1;
            if (ev) begin
                check("o_result", 64'(o_result), 64'(q[0].res));
                check("o_swap",   64'(o_swap),   64'(q[0].swap));
                check("o_equal",  64'(o_equal),  64'(q[0].eq));
                check("o_lzc",    64'(o_lzc),    64'(q[0].lzc));
                check("o_tag",    64'(o_tag),    64'(q[0].tag));
                if (i_ready) void'(q.pop_front());
            end
            if (i_valid && o_ready) begin
                q.push_back(model(fract_a, fract_b, op, tag, cyc));
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (!rst_n) q.delete();
    endtask

    task automatic send(input logic [FRACT_W-1:0] a, input logic [FRACT_W-1:0] b,
                        input logic o, input logic [TAG_W-1:0] t);
        int k = 0;
        i_valid = 1'b1;
        fract_a = a;
        fract_b = b;
        op      = o;
        tag     = t;
        do begin
            cycle();
            k++;
        end while (!accepted && k < 50);
        if (!accepted) check("send_timeout", 64'd1, 64'd0);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (q.size() > 0 && k < 50) begin
            cycle();
            k++;
        end
        check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic check_reset_state();
        check("rst_o_valid",  64'(o_valid),  64'd0);
        check("rst_o_result", 64'(o_result), 64'd0);
        check("rst_o_swap",   64'(o_swap),   64'd0);
        check("rst_o_equal",  64'(o_equal),  64'd0);
        check("rst_o_lzc",    64'(o_lzc),    64'd0);
        check("rst_o_tag",    64'(o_tag),    64'd0);
        check("rst_o_ready",  64'(o_ready),  64'd1);
    endtask

    initial begin
        int sent;
        logic [FRACT_W-1:0] ra, rb;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        fract_a = '0;
        fract_b = '0;
        op      = 1'b0;
        tag     = '0;
        saw_not_ready = 1'b0;
        repeat (3) cycle();
        check_reset_state();
        rst_n = 1'b1;

        // Directed vectors
        send(24'hC00000, 24'h800000, 1'b1, 4'd1);
        send(24'h800001, 24'hFFFFFF, 1'b1, 4'd2);
        send(24'hABCDEF, 24'hABCDEF, 1'b1, 4'd3);
        send(24'hFFFFFF, 24'h800000, 1'b0, 4'd4);
        send(24'h000000, 24'h000000, 1'b0, 4'd5);
        send(24'h000000, 24'h000001, 1'b1, 4'd6);
        drain();

        // Back-to-back stream, tags 0..7
        for (int i = 0; i < 8; i++) begin
            send(FRACT_W'($urandom), FRACT_W'($urandom), 1'($urandom), TAG_W'(i));
        end
        drain();

        // Five ops with the sink stalled for cycles 3..6
        sent = 0;
        saw_not_ready = 1'b0;
        for (int k = 0; k < 40 && (sent < 5 || q.size() > 0); k++) begin
            i_ready = !(k >= 3 && k <= 6);
            i_valid = (sent < 5);
            fract_a = FRACT_W'($urandom);
            fract_b = FRACT_W'($urandom);
            op      = 1'($urandom);
            tag     = TAG_W'(sent + 8);
            cycle();
            if (accepted) sent++;
        end
        check("stall_sent", 64'(sent), 64'd5);
        check("stall_ready_drop", 64'(saw_not_ready), 64'd1);
        drain();

        // Fill both stages, then reset mid-flight
        i_ready = 1'b0;
        send(24'h123456, 24'h654321, 1'b1, 4'd9);
        send(24'h0F0F0F, 24'h00F0F0, 1'b0, 4'd10);
        cycle();
        check("full_o_ready", 64'(o_ready), 64'd0);
        rst_n = 1'b0;
        cycle();
        rst_n   = 1'b1;
        i_ready = 1'b1;
        check_reset_state();
        repeat (5) cycle();

        // Random stream with random valid/ready and biased operand patterns
        for (int k = 0; k < 600; k++) begin
            ra = FRACT_W'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = ra;
                1:       rb = ra ^ (FRACT_W'(1) << $urandom_range(0, FRACT_W - 1));
                2:       rb = '0;
                default: rb = FRACT_W'($urandom);
            endcase
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            fract_a = ra;
            fract_b = rb;
            op      = 1'($urandom);
            tag     = TAG_W'($urandom);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fract_cmp_sub_pipe.md
Name: fract_cmp_sub_pipe

Overview:
- Parametrised, pipelined successor to the FP32 add/sub mantissa difference unit.
- Takes two aligned mantissas (hidden bit included) plus an op select. Produces:
  - the magnitude sum or difference,
  - a swap/compare flag, an equal flag,
  - a leading-zero count for the normaliser.
- Sits between the exponent-align stage and the normalise/round stage of the ADD_SUB datapath.
- Valid/ready handshake on both sides, so the FP pipeline can stall.

Parameters:
- FRACT_W, 24, operand width in bits (23-bit fraction + hidden bit for FP32; 53 for FP64).
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- LZC_W, $clog2(FRACT_W+2), width of the leading-zero count output (derived; not overridden).

Ports:
- i_clk, input, 1, clock; all state updates on the rising edge.
- i_rst_n, input, 1, synchronous active-low reset.
- i_valid, input, 1, upstream has an operation on i_fract_a/i_fract_b/i_op/i_tag.
- o_ready, output, 1, block accepts an operation this cycle.
- i_fract_a, input, FRACT_W, mantissa A.
- i_fract_b, input, FRACT_W, mantissa B.
- i_op, input, 1, 0 = add magnitudes, 1 = subtract magnitudes.
- i_tag, input, TAG_W, sideband passed through unchanged.
- o_valid, output, 1, result outputs are valid.
- i_ready, input, 1, downstream accepts the result this cycle.
- o_result, output, FRACT_W+1, add: A+B with carry in MSB; sub: |A−B| zero-extended.
- o_swap, output, 1, sub: 1 when B > A (result is B−A); add: 0.
- o_equal, output, 1, A == B, valid for both ops.
- o_lzc, output, LZC_W, leading zeros of o_result counted from the MSB (bit FRACT_W); FRACT_W+1 when o_result == 0.
- o_tag, output, TAG_W, i_tag of the operation being presented.

Behaviour:
- Two-stage pipeline, S1 then S2. Each stage has a valid bit and a data register.
- Latency is 2 cycles from an accepted input (i_valid & o_ready) to o_valid.
- Throughput is one operation per cycle when i_ready stays high.
- Stage advance rules:
  - S2 loads when (!s2_valid | i_ready).
  - S1 loads when (!s1_valid | S2 loads).
  - o_ready = (!s1_valid | S2 loads). This is a combinational ready chain; no skid buffer.
- S1 (compare):
  - Registers A, B, op and tag.
  - Registers gt_b = (B > A) and eq = (A == B). Both come from a FRACT_W+1-bit subtract of zero-extended A − B: borrow = MSB, eq = all-zero.
- S2 (compute):
  - op=0: result = {1'b0,A} + {1'b0,B}.
  - op=1 with gt_b: result = B − A.
  - op=1 without gt_b: result = A − B.
  - Registers o_result, o_swap = op & gt_b, o_equal = eq, o_tag, and o_lzc computed from the S2 result.
- Subtract never produces a negative value, and the MSB of o_result is always 0 for subtract.
- A==B with op=1 gives o_result = 0, o_lzc = FRACT_W+1, o_swap = 0, o_equal = 1.
- The output registers hold their value while o_valid & !i_ready (stall). Outputs must not change during a stall.
- When the pipeline is full, i_ready=0 and i_valid=1: o_ready=0 and no operation is accepted or lost.
- A simultaneous S2 drain and S1 refill in the same cycle must sustain full throughput with no bubble.
- Reset, when i_rst_n = 0 at a rising edge:
  - s1_valid and s2_valid clear to 0.
  - o_valid = 0, o_result = 0, o_swap = 0, o_equal = 0, o_lzc = 0, o_tag = 0.
  - o_ready = 1 from the first cycle after reset, being combinational on the cleared valids.
  - Reset in the middle of an operation discards in-flight operations; nothing from them appears after reset.
- Inputs are don't-care when i_valid = 0. The data registers update only on stage load.

Test Plan:
- FRACT_W=24, op=1, A=0xC00000, B=0x800000 -> 2 cycles later: o_result=0x0400000, o_swap=0, o_equal=0, o_lzc=2.
- op=1, A=0x800001, B=0xFFFFFF -> o_result=0x07FFFFE, o_swap=1, o_lzc=2. Then op=1, A=B=0xABCDEF -> o_result=0, o_equal=1, o_swap=0, o_lzc=25.
- op=0, A=0xFFFFFF, B=0x800000 -> o_result=0x17FFFFF (carry set), o_lzc=0, o_swap=0.
- Back-to-back stream of 8 ops with tags 0..7 and i_ready=1 -> o_valid high for 8 consecutive cycles starting 2 cycles after the first accept, tags in order.
- Stream of 5 ops with i_ready=0 for cycles 3–6:
  - o_ready drops once S1 and S2 are both full;
  - o_result and o_tag hold stable while stalled;
  - all 5 results emerge in order with none lost or duplicated.
- Assert i_rst_n=0 for 1 cycle while both stages are valid -> next cycle o_valid=0, o_result=0, o_ready=1; no stale result appears afterwards.
